bus_transfer_ctrl: RTL
======================

// Module: bus_transfer_ctrl
// PURPOSE
//  Downstream stage of the bus arbiter: consumes the one-hot bus_grant vector, latches the granted
//  master's transfer request, executes a burst of 1..2^LEN_W beats on the shared slave port, and
//  returns a one-cycle bus_ack so the arbiter can re-arbitrate. Also steers per-beat data and
//  strobes back to the granted master and aborts stalled transfers after a timeout.
// PARAMETERS
//  TIMEOUT   15  cycles without s_ready in XFER before abort (1..255)
//  (N_MASTERS, ADDR_W=16, DATA_W=32, LEN_W=4 are package constants, not parameters)
// PORTS
//  clk          in   1                  clock
//  reset        in   1                  asynchronous, active-high
//  bus_grant    in   arb_vector         one-hot grant from arbiter; NO_GRANT = idle
//  m_addr       in   addr_t[N_MASTERS]  per-master burst start address
//  m_write      in   [N_MASTERS]        per-master direction, 1 = write
//  m_len        in   len_t[N_MASTERS]   per-master beats-1 (0 => 1 beat, 15 => 16 beats)
//  m_wdata      in   data_t[N_MASTERS]  per-master write data for current beat
//  m_beat_done  out  arb_vector         one-hot strobe to granted master: beat accepted this cycle
//  m_rdata      out  data_t             read data, valid when m_beat_done set and latched write=0
//  s_valid      out  1                  beat request to slave
//  s_write      out  1                  beat direction
//  s_addr       out  addr_t             beat address
//  s_wdata      out  data_t             beat write data
//  s_ready      in   1                  slave completes beat this cycle
//  s_rdata      in   data_t             slave read data, sampled when s_valid & s_ready & !s_write
//  bus_ack      out  1                  one-cycle pulse: transfer finished (normal or aborted)
//  xfer_err     out  1                  one-cycle pulse coincident with bus_ack on abort
// BEHAVIOUR
//  Reset: state IDLE; m_beat_done=NO_GRANT, m_rdata=0, s_valid=0, s_write=0, s_addr=0, s_wdata=0,
//   bus_ack=0, xfer_err=0; beat/timeout counters 0. Reset mid-burst drops the burst immediately, no ack.
//  States: IDLE -> LOAD -> XFER -> DONE -> IDLE. All outputs registered.
//  IDLE: bus_grant==NO_GRANT -> stay. One-hot grant -> latch idx, m_addr[idx], m_write[idx],
//   m_len[idx]; -> LOAD. Multi-hot grant (illegal) -> DONE with err flag set, no slave beat.
//  LOAD: present beat 0: s_valid=1, s_addr=base, s_write=latched dir, s_wdata=m_wdata[idx]; -> XFER.
//  XFER: s_valid held, all s_* outputs stable until s_ready. On s_valid&s_ready: m_beat_done[idx]
//   pulses next cycle (read: m_rdata=s_rdata same cycle); beat_cnt++; s_addr=base+beat_cnt
//   (mod 2^ADDR_W, wraps 0xFFFF->0x0000); s_wdata reloads from m_wdata[idx]. Back-to-back beats
//   allowed (s_ready every cycle => one beat/cycle). After beat with beat_cnt==len: s_valid=0; -> DONE.
//  Timeout: counter clears on each accepted beat, increments each XFER cycle with s_valid&!s_ready;
//   reaching TIMEOUT -> s_valid=0, err flag set, -> DONE. Partial beats already strobed stay valid.
//  DONE: bus_ack=1 for exactly one cycle, xfer_err=err flag; -> IDLE; err flag cleared.
//  Arbiter handshake: arbiter updates bus_grant on the edge that samples bus_ack; IDLE therefore
//   sees the new grant one cycle after DONE. Grant changes during LOAD/XFER/DONE are ignored
//   (latched idx governs). Min cycles grant->ack for 1-beat burst, s_ready=1: 4 (IDLE,LOAD,XFER,DONE).
//  bus_ack never asserted outside DONE; never two acks for one grant.
// STRUCTURE
//  Package arbitration: add ADDR_W, DATA_W, LEN_W, addr_t, data_t, len_t, xfer_state_e enum;
//   reuse N_MASTERS, arb_vector, NO_GRANT.
//  Sub-module grant_encoder: one-hot arb_vector -> index + onehot_ok flag (combinational, $onehot).
//  Top: FSM, beat and timeout counters, per-master input muxes indexed by latched idx.
// TESTING
//  1. grant=0001, m_len[0]=3, write, base 0x0100, s_ready=1 -> s_addr 0x100..0x103, 4 beat_done[0], ack once.
//  2. grant=0100, read len 0, s_ready after 3-cycle stall, s_rdata=0xDEADBEEF -> m_rdata=0xDEADBEEF, ack, no err.
//  3. base=0xFFFE, len=3 -> s_addr 0xFFFE,0xFFFF,0x0000,0x0001.
//  4. s_ready held 0 with TIMEOUT=15 -> s_valid drops after 15 stall cycles, bus_ack&xfer_err pulse together.
//  5. grant 0001->0010 mid-burst -> burst completes for master 0; master 1 served after ack.
//  6. reset asserted in XFER beat 2 -> all outputs 0 same cycle, no ack; next grant runs clean burst.

Source files
------------

// File: rtl/bus_transfer_ctrl_pkg.sv
// bus_transfer_ctrl_pkg: shared widths, types and FSM encoding for the bus transfer controller
package bus_transfer_ctrl_pkg;
  localparam int N_MASTERS = 4;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int LEN_W = 4;
  localparam int IDX_W = $clog2(N_MASTERS);
  typedef logic [N_MASTERS-1:0] arb_vector;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [LEN_W-1:0] len_t;
  typedef logic [IDX_W-1:0] idx_t;
  localparam arb_vector NO_GRANT = '0;
  typedef enum logic [1:0] {IDLE, LOAD, XFER, DONE} xfer_state_e;
  function automatic addr_t beat_addr(addr_t base, len_t k);
    return base + addr_t'(k);
  endfunction
endpackage

// File: rtl/bus_transfer_ctrl_if.sv
// bus_transfer_ctrl_if: grant, per-master request and slave-port signals of the transfer controller
interface bus_transfer_ctrl_if;
  import bus_transfer_ctrl_pkg::*;
  arb_vector bus_grant;
  addr_t [N_MASTERS-1:0] m_addr;
  logic [N_MASTERS-1:0] m_write;
  len_t [N_MASTERS-1:0] m_len;
  data_t [N_MASTERS-1:0] m_wdata;
  arb_vector m_beat_done;
  data_t m_rdata;
  logic s_valid;
  logic s_write;
  addr_t s_addr;
  data_t s_wdata;
  logic s_ready;
  data_t s_rdata;
  logic bus_ack;
  logic xfer_err;
  modport master (
    input bus_grant, m_addr, m_write, m_len, m_wdata, s_ready, s_rdata,
    output m_beat_done, m_rdata, s_valid, s_write, s_addr, s_wdata, bus_ack, xfer_err
  );
  modport slave (
    output bus_grant, m_addr, m_write, m_len, m_wdata, s_ready, s_rdata,
    input m_beat_done, m_rdata, s_valid, s_write, s_addr, s_wdata, bus_ack, xfer_err
  );
endinterface

// File: rtl/bus_transfer_ctrl_grant_encoder.sv
// bus_transfer_ctrl_grant_encoder: one-hot grant vector to master index plus legality flag
module bus_transfer_ctrl_grant_encoder
  import bus_transfer_ctrl_pkg::*;
(
  input  arb_vector grant,
  output idx_t      idx,
  output logic      onehot_ok
);
  // index of the set grant bit; only meaningful when onehot_ok
  always_comb begin
    idx = '0;
    for (int i = 0; i < N_MASTERS; i++) if (grant[i]) idx = idx_t'(i);
  end
  assign onehot_ok = $onehot(grant);
endmodule

// File: rtl/bus_transfer_ctrl.sv
// bus_transfer_ctrl: executes the granted master's burst on the slave port and acks the arbiter
module bus_transfer_ctrl
  import bus_transfer_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic reset,
  bus_transfer_ctrl_if.master bus
);
  xfer_state_e state_q, state_d;
  idx_t idx_q, idx_d, gnt_idx;
  logic gnt_ok;
  addr_t base_q, base_d;
  logic write_q, write_d;
  len_t len_q, len_d, beat_cnt_q, beat_cnt_d;
  logic [7:0] tmo_q, tmo_d;
  logic s_valid_q, s_valid_d, s_write_q, s_write_d;
  addr_t s_addr_q, s_addr_d;
  data_t s_wdata_q, s_wdata_d, m_rdata_q, m_rdata_d;
  arb_vector m_beat_done_q, m_beat_done_d;
  logic bus_ack_q, bus_ack_d, xfer_err_q, xfer_err_d;
  logic granted, fire, last, tmo_hit;

  bus_transfer_ctrl_grant_encoder u_enc (
    .grant(bus.bus_grant),
    .idx(gnt_idx),
    .onehot_ok(gnt_ok)
  );

  assign granted = state_q == IDLE && bus.bus_grant != NO_GRANT;
  assign fire = state_q == XFER && s_valid_q && bus.s_ready;
  assign last = beat_cnt_q == len_q;
  assign tmo_hit = state_q == XFER && s_valid_q && !bus.s_ready && tmo_q == 8'(TIMEOUT - 1);

  // state and datapath registers; reset drops any burst in flight without an ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      base_q <= '0;
      write_q <= 1'b0;
      len_q <= '0;
      beat_cnt_q <= '0;
      tmo_q <= '0;
      s_valid_q <= 1'b0;
      s_write_q <= 1'b0;
      s_addr_q <= '0;
      s_wdata_q <= '0;
      m_rdata_q <= '0;
      m_beat_done_q <= NO_GRANT;
      bus_ack_q <= 1'b0;
      xfer_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      base_q <= base_d;
      write_q <= write_d;
      len_q <= len_d;
      beat_cnt_q <= beat_cnt_d;
      tmo_q <= tmo_d;
      s_valid_q <= s_valid_d;
      s_write_q <= s_write_d;
      s_addr_q <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      m_rdata_q <= m_rdata_d;
      m_beat_done_q <= m_beat_done_d;
      bus_ack_q <= bus_ack_d;
      xfer_err_q <= xfer_err_d;
    end
  end

  // next state: illegal multi-hot grants skip straight to DONE to be acked with an error
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (granted) state_d = gnt_ok ? LOAD : DONE;
      LOAD: state_d = XFER;
      XFER: if ((fire && last) || tmo_hit) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // registered outputs are computed one cycle early so bus_ack is high exactly while in DONE
  always_comb begin
    idx_d = idx_q;
    base_d = base_q;
    write_d = write_q;
    len_d = len_q;
    beat_cnt_d = beat_cnt_q;
    tmo_d = tmo_q;
    s_valid_d = s_valid_q;
    s_write_d = s_write_q;
    s_addr_d = s_addr_q;
    s_wdata_d = s_wdata_q;
    m_rdata_d = m_rdata_q;
    m_beat_done_d = NO_GRANT;
    bus_ack_d = 1'b0;
    xfer_err_d = 1'b0;
    if (granted) begin
      idx_d = gnt_idx;
      base_d = bus.m_addr[gnt_idx];
      write_d = bus.m_write[gnt_idx];
      len_d = bus.m_len[gnt_idx];
      beat_cnt_d = '0;
      tmo_d = '0;
      bus_ack_d = !gnt_ok;
      xfer_err_d = !gnt_ok;
    end
    if (state_q == LOAD) begin
      s_valid_d = 1'b1;
      s_write_d = write_q;
      s_addr_d = base_q;
      s_wdata_d = bus.m_wdata[idx_q];
    end
    if (fire) begin
      m_beat_done_d = arb_vector'(1) << idx_q;
      m_rdata_d = write_q ? m_rdata_q : bus.s_rdata;
      tmo_d = '0;
      s_valid_d = !last;
      bus_ack_d = last;
      beat_cnt_d = last ? beat_cnt_q : beat_cnt_q + len_t'(1);
      s_addr_d = last ? s_addr_q : beat_addr(base_q, beat_cnt_q + len_t'(1));
      s_wdata_d = last ? s_wdata_q : bus.m_wdata[idx_q];
    end else if (state_q == XFER && s_valid_q) begin
      tmo_d = tmo_q + 8'd1;
      s_valid_d = !tmo_hit;
      bus_ack_d = tmo_hit;
      xfer_err_d = tmo_hit;
    end
  end

  assign bus.s_valid = s_valid_q;
  assign bus.s_write = s_write_q;
  assign bus.s_addr = s_addr_q;
  assign bus.s_wdata = s_wdata_q;
  assign bus.m_rdata = m_rdata_q;
  assign bus.m_beat_done = m_beat_done_q;
  assign bus.bus_ack = bus_ack_q;
  assign bus.xfer_err = xfer_err_q;
endmodule
